// File: rtl/ddr_rd_arbiter_if.sv
// Request/response bus between the requesters, the read arbiter and the DDR read port.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface ddr_rd_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 26
);
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [ADDR_WIDTH-1:0]         ddr_rd_req_addr;
   logic                          ddr_rd_req_valid;
   logic                          ddr_rd_req_almost_full;
   logic [511:0]                  ddr_rd_resp_data;
   logic                          ddr_rd_resp_valid;
   logic [511:0]                  resp_data;
   logic [NUM_REQ-1:0]            resp_valid;

   modport slave (
      input  req_addr, req_valid, ddr_rd_req_almost_full, ddr_rd_resp_data, ddr_rd_resp_valid,
      output req_ready, ddr_rd_req_addr, ddr_rd_req_valid, resp_data, resp_valid
   );

   modport master (
      output req_addr, req_valid, ddr_rd_req_almost_full, ddr_rd_resp_data, ddr_rd_resp_valid,
      input  req_ready, ddr_rd_req_addr, ddr_rd_req_valid, resp_data, resp_valid
   );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read-request channel between NUM_REQ requesters.
// A tag FIFO remembers the owner of each in-order read so responses are steered back.
module ddr_rd_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 26,
   parameter int MAX_OUTST  = 32,
   parameter int TAG_DEPTH  = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   ddr_rd_arbiter_if.slave      bus,
   output logic [NUM_REQ*6-1:0] outst_cnt,
   output logic                 tag_err
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [5:0]       OUTST_LIMIT = 6'(MAX_OUTST);
   localparam logic [CNT_W-1:0] TAG_FULL    = CNT_W'(TAG_DEPTH);
   localparam logic [IDX_W:0]   NUM_REQ_W   = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      tag_mem [TAG_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      tag_count;

   logic                  chan_open;
   logic [NUM_REQ-1:0]    eligible;
   logic [IDX_W:0]        cand;
   logic                  grant_any;
   logic [IDX_W-1:0]      grant_idx;
   logic [IDX_W-1:0]      next_ptr;
   logic [NUM_REQ-1:0]    grant_vec;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic                  tag_empty;
   logic                  pop;
   logic [IDX_W-1:0]      head;
   logic [NUM_REQ-1:0]    resp_onehot;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Eligibility: channel open (no backpressure, tag space left, not in reset) and credit left.
   always_comb begin
      chan_open = !bus.ddr_rd_req_almost_full && (tag_count != TAG_FULL) && !rst;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = chan_open && bus.req_valid[i] && (outst_cnt[i*6 +: 6] < OUTST_LIMIT);
      end
   end

   // Round-robin search starting at rr_ptr; the first eligible requester wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int o = 0; o < NUM_REQ; o++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(o);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end else begin
            cand = cand;
         end
         if (!grant_any && eligible[cand[IDX_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end else begin
            grant_any = grant_any;
         end
      end
   end

   // Grant vector, winning address and pointer successor.
   always_comb begin
      grant_vec  = '0;
      grant_addr = '0;
      if (grant_any) begin
         grant_vec[grant_idx] = 1'b1;
      end else begin
         grant_vec = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_vec[i]) begin
            grant_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end else begin
            grant_addr = grant_addr;
         end
      end
      if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = grant_idx + IDX_W'(1);
      end
   end

   // A response with an empty tag FIFO is dropped rather than popped.
   always_comb begin
      tag_empty = (tag_count == '0);
      pop       = bus.ddr_rd_resp_valid && !tag_empty;
      head      = tag_mem[rd_ptr];
      if (pop) begin
         resp_onehot = onehot(head);
      end else begin
         resp_onehot = '0;
      end
   end

   assign bus.req_ready = grant_vec;

   // Request/response registers, tag FIFO and per-requester credit counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr               <= '0;
         bus.ddr_rd_req_valid <= 1'b0;
         bus.ddr_rd_req_addr  <= '0;
         bus.resp_data        <= '0;
         bus.resp_valid       <= '0;
         tag_err              <= 1'b0;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         tag_count            <= '0;
         outst_cnt            <= '0;
         for (int t = 0; t < TAG_DEPTH; t++) begin
            tag_mem[t] <= '0;
         end
      end else begin
         bus.ddr_rd_req_valid <= grant_any;
         bus.resp_valid       <= resp_onehot;
         if (grant_any) begin
            rr_ptr              <= next_ptr;
            bus.ddr_rd_req_addr <= grant_addr;
            tag_mem[wr_ptr]     <= grant_idx;
            wr_ptr              <= wr_ptr + PTR_W'(1);
         end
         if (bus.ddr_rd_resp_valid) begin
            bus.resp_data <= bus.ddr_rd_resp_data;
         end
         if (bus.ddr_rd_resp_valid && tag_empty) begin
            tag_err <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({grant_any, pop})
            2'b10:   tag_count <= tag_count + CNT_W'(1);
            2'b01:   tag_count <= tag_count - CNT_W'(1);
            default: tag_count <= tag_count;
         endcase
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({grant_vec[i], resp_onehot[i]})
               2'b10:   outst_cnt[i*6 +: 6] <= outst_cnt[i*6 +: 6] + 6'd1;
               2'b01:   outst_cnt[i*6 +: 6] <= outst_cnt[i*6 +: 6] - 6'd1;
               default: outst_cnt[i*6 +: 6] <= outst_cnt[i*6 +: 6];
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model (credit array, owner queue, rotating priority).
module tb_ddr_rd_arbiter;
   localparam int N  = 2;
   localparam int AW = 26;
   localparam int MO = 32;
   localparam int TD = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N*6-1:0] outst_cnt;
   logic tag_err;

   always #5 clk = ~clk;

   ddr_rd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW)) bus ();

   ddr_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MAX_OUTST(MO), .TAG_DEPTH(TD)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .outst_cnt (outst_cnt),
      .tag_err   (tag_err)
   );

   // stimulus
   logic [AW-1:0]  a [N];
   logic [N-1:0]   v = '0;
   logic           af = 1'b0;
   logic           rv = 1'b0;
   logic [511:0]   rd = '0;

   // reference model
   int             m_outst [N];
   int             m_ptr;
   int             m_tags [$];
   bit             m_err;
   bit             m_ddr_v;
   logic [AW-1:0]  m_ddr_a;
   logic [N-1:0]   m_rv;
   logic [511:0]   m_rd;
   logic [N-1:0]   exp_ready;

   // observations
   logic [N-1:0]   obs_ready;
   logic           obs_ddr_v;
   logic [AW-1:0]  obs_ddr_a;
   logic [N-1:0]   obs_rv;
   logic [511:0]   obs_rd;
   logic [N*6-1:0] obs_outst;
   logic           obs_err;

   int n_total = 0;
   int n_pass  = 0;

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: drive inputs, sample ready, advance the model, sample registered outputs.
   task automatic tick();
      int gk;
      int j;
      int own;
      bus.req_valid = v;
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a[i];
      bus.ddr_rd_req_almost_full = af;
      bus.ddr_rd_resp_valid      = rv;
      bus.ddr_rd_resp_data       = rd;
      #1;
      obs_ready = bus.req_ready;
      gk = -1;
      if (!rst && !af && m_tags.size() < TD) begin
         for (int o = 0; o < N; o++) begin
            j = (m_ptr + o) % N;
            if (gk < 0 && v[j] && m_outst[j] < MO) gk = j;
         end
      end
      exp_ready = '0;
      if (gk >= 0) exp_ready[gk] = 1'b1;
      if (rst) begin
         for (int i = 0; i < N; i++) m_outst[i] = 0;
         m_ptr = 0; m_tags.delete(); m_err = 1'b0;
         m_ddr_v = 1'b0; m_ddr_a = '0; m_rv = '0; m_rd = '0;
      end else begin
         m_ddr_v = (gk >= 0);
         if (gk >= 0) m_ddr_a = a[gk];
         m_rv = '0;
         if (rv) begin
            m_rd = rd;
            if (m_tags.size() == 0) m_err = 1'b1;
            else begin
               own = m_tags.pop_front();
               m_rv[own] = 1'b1;
               m_outst[own]--;
            end
         end
         if (gk >= 0) begin
            m_tags.push_back(gk);
            m_outst[gk]++;
            m_ptr = (gk + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      obs_ddr_v = bus.ddr_rd_req_valid;
      obs_ddr_a = bus.ddr_rd_req_addr;
      obs_rv    = bus.resp_valid;
      obs_rd    = bus.resp_data;
      obs_outst = outst_cnt;
      obs_err   = tag_err;
      for (int i = 0; i < N; i++) if (obs_ready[i]) v[i] = 1'b0;
      rv = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && (m_tags.size() > 0 || v != '0); k++) begin
         rv = (m_tags.size() > 0);
         rd = rnd512();
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v = '1;
      for (int i = 0; i < N; i++) a[i] = AW'($urandom);
      tick();
      tick();
      n_total++; if (obs_ready !== '0) $display("FAIL reset_ready got %b want 0", obs_ready); else n_pass++;
      n_total++; if (obs_ddr_v !== 1'b0 || obs_ddr_a !== '0) $display("FAIL reset_ddr got v=%b a=%h want 0", obs_ddr_v, obs_ddr_a); else n_pass++;
      n_total++; if (obs_rv !== '0 || obs_rd !== '0) $display("FAIL reset_resp got v=%b d=%h want 0", obs_rv, obs_rd[31:0]); else n_pass++;
      n_total++; if (obs_outst !== '0 || obs_err !== 1'b0) $display("FAIL reset_cnt got outst=%h err=%b want 0", obs_outst, obs_err); else n_pass++;
      rst = 1'b0;
      v = '0;
      tick();
   endtask

   task automatic test_single();
      v[0] = 1'b1;
      a[0] = 26'h123;
      tick();
      n_total++; if (obs_ready !== 2'b01) $display("FAIL single_ready got %b want 01", obs_ready); else n_pass++;
      n_total++; if (obs_ddr_v !== 1'b1 || obs_ddr_a !== 26'h123) $display("FAIL single_ddr got v=%b a=%h want 1/123", obs_ddr_v, obs_ddr_a); else n_pass++;
      n_total++; if (obs_outst[5:0] !== 6'd1) $display("FAIL single_outst1 got %0d want 1", obs_outst[5:0]); else n_pass++;
      tick();
      n_total++; if (obs_ddr_v !== 1'b0) $display("FAIL single_strobe got %b want 0", obs_ddr_v); else n_pass++;
      rv = 1'b1;
      rd = {64{8'hAB}};
      tick();
      n_total++; if (obs_rv !== 2'b01 || obs_rd !== {64{8'hAB}}) $display("FAIL single_resp got v=%b d=%h want 01/ab..", obs_rv, obs_rd[31:0]); else n_pass++;
      n_total++; if (obs_outst[5:0] !== 6'd0) $display("FAIL single_outst0 got %0d want 0", obs_outst[5:0]); else n_pass++;
      tick();
      n_total++; if (obs_rv !== 2'b00 || obs_rd !== {64{8'hAB}}) $display("FAIL single_hold got v=%b d=%h want 00/ab..", obs_rv, obs_rd[31:0]); else n_pass++;
   endtask

   task automatic test_fairness();
      int cnt [N];
      int prev;
      prev = -1;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!v[i]) begin v[i] = 1'b1; a[i] = AW'($urandom); end
         tick();
         n_total++; if (obs_ready !== exp_ready) $display("FAIL fair_grant got %b want %b", obs_ready, exp_ready); else n_pass++;
         for (int i = 0; i < N; i++) if (obs_ready[i]) begin
            cnt[i]++;
            n_total++; if (i == prev) $display("FAIL fair_alternate got repeat of %0d want other", i); else n_pass++;
            prev = i;
         end
      end
      n_total++; if (cnt[0] != 4 || cnt[1] != 4) $display("FAIL fair_count got %0d/%0d want 4/4", cnt[0], cnt[1]); else n_pass++;
      v = '0;
      for (int c = 0; c < 8; c++) begin
         rv = 1'b1;
         rd = rnd512();
         tick();
         n_total++; if (obs_rv !== m_rv || obs_rd !== rd) $display("FAIL fair_resp got %b want %b", obs_rv, m_rv); else n_pass++;
         n_total++; if (c > 0 && obs_rv == prev_rv_bits(c)) $display("FAIL fair_resp_alt got %b twice", obs_rv); else n_pass++;
      end
   endtask

   logic [N-1:0] last_rv = '0;
   function automatic logic [N-1:0] prev_rv_bits(input int c);
      logic [N-1:0] r;
      r = last_rv;
      last_rv = obs_rv;
      if (c == 0) r = '0;
      return r;
   endfunction

   task automatic test_backpressure();
      int saved;
      v = '1;
      for (int i = 0; i < N; i++) a[i] = AW'($urandom);
      af = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_total++; if (obs_ready !== '0 || obs_ddr_v !== 1'b0) $display("FAIL bp_block got rdy=%b ddrv=%b want 0", obs_ready, obs_ddr_v); else n_pass++;
      end
      saved = m_ptr;
      af = 1'b0;
      tick();
      n_total++; if (obs_ready !== (N'(1) << saved)) $display("FAIL bp_resume got %b want ptr %0d", obs_ready, saved); else n_pass++;
      drain();
   endtask

   task automatic test_credit();
      int g;
      g = 0;
      for (int c = 0; c < 40; c++) begin
         if (!v[0]) begin v[0] = 1'b1; a[0] = AW'($urandom); end
         tick();
         if (obs_ready[0]) g++;
         n_total++; if (obs_ready !== exp_ready) $display("FAIL credit_grant got %b want %b", obs_ready, exp_ready); else n_pass++;
      end
      n_total++; if (g != MO) $display("FAIL credit_total got %0d want %0d", g, MO); else n_pass++;
      n_total++; if (obs_outst[5:0] !== 6'd32) $display("FAIL credit_outst got %0d want 32", obs_outst[5:0]); else n_pass++;
      g = 0;
      rv = 1'b1;
      rd = rnd512();
      for (int c = 0; c < 6; c++) begin
         if (!v[0]) begin v[0] = 1'b1; a[0] = AW'($urandom); end
         tick();
         if (obs_ready[0]) g++;
      end
      n_total++; if (g != 1) $display("FAIL credit_refill got %0d want 1", g); else n_pass++;
      n_total++; if (obs_outst[5:0] !== 6'd32) $display("FAIL credit_outst2 got %0d want 32", obs_outst[5:0]); else n_pass++;
      drain();
   endtask

   task automatic test_simultaneous();
      int g;
      g = 0;
      for (int c = 0; c < 20 && g < 5; c++) begin
         if (!v[1]) begin v[1] = 1'b1; a[1] = AW'($urandom); end
         tick();
         if (obs_ready[1]) g++;
      end
      n_total++; if (obs_outst[11:6] !== 6'd5) $display("FAIL simul_pre got %0d want 5", obs_outst[11:6]); else n_pass++;
      v[1] = 1'b1;
      a[1] = AW'($urandom);
      rv = 1'b1;
      rd = rnd512();
      tick();
      n_total++; if (obs_ready !== 2'b10) $display("FAIL simul_grant got %b want 10", obs_ready); else n_pass++;
      n_total++; if (obs_outst[11:6] !== 6'd5 || obs_rv !== 2'b10) $display("FAIL simul_outst got %0d rv=%b want 5/10", obs_outst[11:6], obs_rv); else n_pass++;
      for (int c = 0; c < 5; c++) begin
         rv = 1'b1;
         rd = rnd512();
         tick();
         n_total++; if (obs_rv !== 2'b10) $display("FAIL simul_drain got %b want 10", obs_rv); else n_pass++;
      end
      rv = 1'b1;
      tick();
      n_total++; if (obs_rv !== 2'b00 || obs_err !== 1'b1) $display("FAIL err_empty got rv=%b err=%b want 00/1", obs_rv, obs_err); else n_pass++;
      for (int c = 0; c < 3; c++) tick();
      n_total++; if (obs_err !== 1'b1) $display("FAIL err_sticky got %b want 1", obs_err); else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < N; i++) if (!v[i]) begin v[i] = 1'b1; a[i] = AW'($urandom); end
         tick();
      end
      n_total++; if (m_tags.size() != 3) $display("FAIL rstmid_inflight got %0d want 3", m_tags.size()); else n_pass++;
      v = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++; if (obs_outst !== '0 || obs_err !== 1'b0 || obs_rv !== '0) $display("FAIL rstmid_clear got outst=%h err=%b rv=%b want 0", obs_outst, obs_err, obs_rv); else n_pass++;
      rv = 1'b1;
      rd = rnd512();
      tick();
      n_total++; if (obs_rv !== '0 || obs_err !== 1'b1) $display("FAIL rstmid_late got rv=%b err=%b want 0/1", obs_rv, obs_err); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) if (!v[i] && $urandom_range(1, 0) == 1) begin v[i] = 1'b1; a[i] = AW'($urandom); end
         af = ($urandom_range(4, 0) == 0);
         rv = (m_tags.size() > 0) && ($urandom_range(2, 0) != 0);
         rd = rnd512();
         tick();
         n_total++; if (obs_ready !== exp_ready) $display("FAIL rnd_ready cyc %0d got %b want %b", c, obs_ready, exp_ready); else n_pass++;
         n_total++; if (obs_ddr_v !== m_ddr_v || (m_ddr_v && obs_ddr_a !== m_ddr_a)) $display("FAIL rnd_ddr cyc %0d got %b/%h want %b/%h", c, obs_ddr_v, obs_ddr_a, m_ddr_v, m_ddr_a); else n_pass++;
         n_total++; if (obs_rv !== m_rv || obs_rd !== m_rd) $display("FAIL rnd_resp cyc %0d got %b/%h want %b/%h", c, obs_rv, obs_rd[31:0], m_rv, m_rd[31:0]); else n_pass++;
         bad = 0;
         for (int i = 0; i < N; i++) if (obs_outst[i*6 +: 6] !== 6'(m_outst[i])) bad++;
         n_total++; if (bad != 0 || obs_err !== m_err) $display("FAIL rnd_cnt cyc %0d got %h/%b want %0d,%0d/%b", c, obs_outst, obs_err, m_outst[0], m_outst[1], m_err); else n_pass++;
      end
      af = 1'b0;
      drain();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin a[i] = '0; m_outst[i] = 0; end
      m_ptr = 0; m_err = 1'b0; m_ddr_v = 1'b0; m_ddr_a = '0; m_rv = '0; m_rd = '0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_credit();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
- Shares the single DDR read-request channel between NUM_REQ requesters, for example the PDU data mover and a CPU-directed PDU fetch engine.
- Each request reads one 512-bit line. Grants are round-robin and respect DDR almost_full backpressure plus per-requester outstanding credits.
- The DDR returns responses in order. The block records the requester ID of every granted read in an internal tag FIFO and steers each response back to its owner.
- Sits between the requesters and the DDR read request/response ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 26, 64-byte-line address width.
- MAX_OUTST, 32, maximum in-flight reads per requester.
- TAG_DEPTH, 64, tag FIFO depth, power of 2, >= total in-flight reads.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester line address; slice i belongs to requester i
- req_valid  in  NUM_REQ  request valid
- req_ready  out  NUM_REQ  grant; the request transfers when valid&ready
- ddr_rd_req_addr  out  ADDR_WIDTH  address to DDR
- ddr_rd_req_valid  out  1  DDR read request strobe
- ddr_rd_req_almost_full  in  1  DDR request queue almost full
- ddr_rd_resp_data  in  512  DDR read data
- ddr_rd_resp_valid  in  1  DDR read data valid; cannot be stalled
- resp_data  out  512  response data, common to all requesters
- resp_valid  out  NUM_REQ  one-hot response valid
- outst_cnt  out  NUM_REQ*6  per-requester in-flight count
- tag_err  out  1  sticky error: response arrived with an empty tag FIFO

Behaviour:
- Reset clears every output and internal register to 0: req_ready, ddr_rd_req_valid, ddr_rd_req_addr, resp_valid, resp_data, outst_cnt, tag_err, the RR pointer, and the tag FIFO (reset leaves it empty).
- Reset mid-operation drops all in-flight tags. Responses arriving after reset set tag_err.

Eligibility and grant:
- Requester i is eligible when req_valid[i] && outst[i] < MAX_OUTST.
- Eligibility is only considered when the channel is open: !ddr_rd_req_almost_full && tag FIFO not full.
- At most one grant per cycle, combinational from the current inputs and the RR pointer.
- The RR pointer names the highest-priority requester. Search order is ptr, ptr+1, ... mod NUM_REQ.
- After a grant to requester k, ptr <= (k+1) mod NUM_REQ. With no grant the pointer holds.
- req_ready[k] = 1 in the grant cycle only. Requesters must hold req_addr and req_valid stable until ready.

DDR request path:
- Registered, latency 1 cycle: ddr_rd_req_valid <= grant_any; ddr_rd_req_addr <= addr[k].
- ddr_rd_req_valid is a one-cycle strobe per granted request.
- almost_full is honoured in the grant cycle. The DDR side tolerates the one-cycle skid.

Tag FIFO:
- Pushes k on grant and pops on ddr_rd_resp_valid.
- Push and pop in the same cycle are both performed; the count is unchanged.
- Pointers wrap modulo TAG_DEPTH. Full/empty are tracked by a count of width log2(TAG_DEPTH)+1.

Response path:
- Registered, latency 1 cycle: resp_data <= ddr_rd_resp_data; resp_valid <= onehot(tag head).
- resp_data updates only on ddr_rd_resp_valid and holds otherwise.
- resp_valid is 0 in cycles without a response.
- Requesters must accept every response; they size their buffers to MAX_OUTST lines.
- A response arriving with the tag FIFO empty is dropped: resp_valid stays 0 and tag_err is set sticky until rst.

Outstanding counters:
- outst[i] +1 on grant to i, -1 on a response to i (the pop in the ddr_rd_resp_valid cycle).
- Simultaneous grant and response for the same i leaves outst[i] unchanged.
- outst[i] never exceeds MAX_OUTST, because grant is blocked at the limit.
- outst_cnt is the registered value of outst.

Test Plan:
- Single request: rst, then req_valid[0]=1 with addr 0x123 → req_ready[0] at cycle t. At t+1, ddr_rd_req_valid=1 and ddr_rd_req_addr=0x123. DDR returns data 0xAB..AB → resp_valid=2'b01 and resp_data=0xAB..AB one cycle later; outst_cnt[0] goes 1 then 0.
- Fairness: both requesters valid continuously, no backpressure → grants alternate 0,1,0,1. After 8 grants each requester has 4. DDR returns 8 responses in order → resp_valid sequence 01,10,01,10,...
- Backpressure: assert ddr_rd_req_almost_full for 5 cycles while both are valid → no req_ready and no ddr_rd_req_valid during those cycles. On deassert, grants resume at the requester the RR pointer held.
- Credit limit: MAX_OUTST=32, requester 0 valid only, no responses → exactly 32 grants, then req_ready[0] stays 0. One response → exactly one more grant; outst_cnt[0]=32.
- Simultaneous grant and response: outst[1]=5, grant to 1 in the same cycle as a response tagged 1 → outst_cnt[1] stays 5; tag FIFO count unchanged.
- Error and reset: ddr_rd_resp_valid with the tag FIFO empty → resp_valid=0 and tag_err=1 and stays 1. Assert rst mid-stream with 3 in flight → all counters are 0, the FIFO is empty and tag_err=0 on the next cycle. A late response then sets tag_err=1.
